mem_port_arbiter: RTL

- Shares the core's single memory port between the fetch stage (instruction requester) and the mem stage (data requester).
- Req/gnt/rvalid handshake on all sides; at most one transaction outstanding.
- Data requests have fixed priority. A starvation counter guarantees fetch forward progress.
- Fetch responses are discarded when the pipeline flushes on a taken branch.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and mem-stage requesters with a single
// outstanding transaction, fixed data priority and a fetch starvation counter.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic [31:0] dm_addr_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_be_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_gnt_o,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic {IDLE, WAIT_RSP} state_t;
    typedef enum logic {OWN_DM, OWN_IF} owner_t;

    state_t           state, state_next;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             drop;
    logic             dm_first, pick_if, pick_dm, issue;

    always_comb begin
        dm_first    = dm_req_i && (starve_cnt < CNT_W'(STARVE_LIMIT));
        pick_if     = if_req_i && !dm_first;
        pick_dm     = dm_req_i && !pick_if;
        // Requests are masked while reset is held so every output reads 0.
        issue       = rstn_i && (state == IDLE) && (if_req_i || dm_req_i);

        state_next  = state;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;
        busy_o      = (state == WAIT_RSP);

        if (issue) begin
            mem_req_o = 1'b1;
            if (pick_if) begin
                mem_addr_o = if_addr_i;
                mem_be_o   = '1;
                if_gnt_o   = mem_gnt_i;
            end else begin
                mem_addr_o  = dm_addr_i;
                mem_we_o    = dm_we_i;
                mem_be_o    = dm_be_i;
                mem_wdata_o = dm_wdata_i;
                dm_gnt_o    = mem_gnt_i;
            end
            if (mem_gnt_i) state_next = WAIT_RSP;
        end

        if (state == WAIT_RSP && mem_rvalid_i) begin
            state_next = IDLE;
            if (owner == OWN_DM) begin
                dm_rvalid_o = 1'b1;
                dm_rdata_o  = mem_rdata_i;
            end else if (!drop && !if_flush_i) begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            owner      <= OWN_DM;
            starve_cnt <= '0;
            drop       <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (mem_rvalid_i) err_o <= 1'b1;
                if (issue && mem_gnt_i) begin
                    owner <= pick_if ? OWN_IF : OWN_DM;
                    drop  <= pick_if && if_flush_i;
                end
                if (if_gnt_o)
                    starve_cnt <= '0;
                else if (if_req_i && starve_cnt != '1)
                    starve_cnt <= starve_cnt + 1'b1;
            end else if (mem_rvalid_i) begin
                drop <= 1'b0;
            end else if (owner == OWN_IF && if_flush_i) begin
                drop <= 1'b1;
            end
        end
    end

endmodule
